// File: rtl/conv2_dw.sv
// conv2_dw: 3x3 depthwise convolution, stride 1, no padding, 8 channels of
// 8-bit signed activations per pixel, raster-order input without backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   in_valid   in_act/in_sof carry one pixel this cycle
//   in_sof     pixel is row 0, col 0 of a frame (qualified by in_valid)
//   in_act     8 x 8-bit signed channels, channel c at [8c+7:8c]
//   out_act    8 x 8-bit requantised results, held while out_valid=0
//   out_valid  out_act holds a new output pixel (2 cycles after trigger)
//   out_eof    with out_valid on the last output pixel of a frame
module conv2_dw #(
  parameter int unsigned        IMG_W      = 16,
  parameter int unsigned        IMG_H      = 16,
  parameter logic [72*16-1:0]   DW_WEIGHTS = {72{16'sd16384}},
  parameter logic [8*16-1:0]    DW_BIAS    = '0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [63:0] in_act,
  output logic [63:0] out_act,
  output logic        out_valid,
  output logic        out_eof
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            accept;
  logic            fire;
  logic            last_hit;
  logic [CW-1:0]   pix_col;

  logic [63:0]     lb1 [IMG_W];   // row r-1
  logic [63:0]     lb2 [IMG_W];   // row r-2
  logic [63:0]     win [3][3];    // [ky][kx], index 0 = oldest

  logic            v1, e1;
  logic signed [31:0] acc [8];
  logic [63:0]     q_act;

  // row_q/col_q always name the position of the next expected pixel; an sof
  // pixel is itself (0,0), so the counters jump straight to (0,1).
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    accept   = 1'b0;
    fire     = 1'b0;
    last_hit = 1'b0;
    pix_col  = col_q;
    if (in_valid) begin
      if (in_sof) begin
        accept  = 1'b1;
        pix_col = '0;
        state_d = ACTIVE;
        row_d   = '0;
        col_d   = CW'(1);
      end else if (state_q == ACTIVE) begin
        accept = 1'b1;
        fire   = (row_q >= RW'(2)) && (col_q >= CW'(2));
        if (col_q == CW'(IMG_W - 1)) begin
          col_d = '0;
          if (row_q == RW'(IMG_H - 1)) begin
            row_d    = '0;
            state_d  = WAIT_SOF;
            last_hit = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= WAIT_SOF;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Line buffers and window carry data only; validity is tracked by v1, and a
  // window is only used once three columns of the current frame have shifted in.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[pix_col] <= lb1[pix_col];
      lb1[pix_col] <= in_act;
      for (int unsigned ky = 0; ky < 3; ky++) begin
        win[ky][0] <= win[ky][1];
        win[ky][1] <= win[ky][2];
      end
      win[0][2] <= lb2[pix_col];
      win[1][2] <= lb1[pix_col];
      win[2][2] <= in_act;
    end
  end

  always_comb begin
    q_act = '0;
    for (int unsigned c = 0; c < 8; c++) begin
      acc[c] = $signed({16'd0, DW_BIAS[c*16 +: 16]});
      for (int unsigned ky = 0; ky < 3; ky++) begin
        for (int unsigned kx = 0; kx < 3; kx++) begin
          acc[c] = acc[c]
                 + 32'($signed(DW_WEIGHTS[(c*9 + ky*3 + kx)*16 +: 16]))
                 * 32'($signed(win[ky][kx][c*8 +: 8]));
        end
      end
      if (acc[c] < 0)
        q_act[c*8 +: 8] = 8'd0;
      else if (acc[c][31:22] != 10'd0)
        q_act[c*8 +: 8] = 8'd127;
      else
        q_act[c*8 +: 8] = {1'b0, acc[c][21:15]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1        <= 1'b0;
      e1        <= 1'b0;
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      out_act   <= '0;
    end else begin
      v1        <= fire;
      e1        <= last_hit;
      out_valid <= v1;
      out_eof   <= e1;
      if (v1)
        out_act <= q_act;
    end
  end

endmodule

// File: tb/tb_conv2_dw.sv
// tb_conv2_dw: directed bench for conv2_dw with default parameters (16x16,
// all weights 16384, zero bias). Expected outputs come from a window-sum
// model: acc = 16384*S, so out = S<0 ? 0 : S>=256 ? 127 : S>>1.
module tb_conv2_dw;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_sof;
  logic [63:0] in_act;
  logic [63:0] out_act;
  logic        out_valid;
  logic        out_eof;

  int tests  = 0;
  int failed = 0;
  int n_out  = 0;
  int n_eof  = 0;

  logic        fire_now = 1'b0;
  logic        eof_now  = 1'b0;
  logic        pv1, pv2, pe1, pe2;
  logic [63:0] exp_q [$];
  logic [63:0] last_act = '0;
  logic [63:0] exp_v;

  conv2_dw #(.IMG_W(16), .IMG_H(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_act    (in_act),
    .out_act   (out_act),
    .out_valid (out_valid),
    .out_eof   (out_eof)
  );

  always #5 clk = ~clk;

  function automatic int pixb(input int mode, input int cv, input int r, input int c, input int ch);
    if (mode == 0) return cv;
    return r + c + ch;
  endfunction

  function automatic logic [63:0] pixvec(input int mode, input int cv, input int r, input int c);
    logic [63:0] v;
    int b;
    v = '0;
    for (int ch = 0; ch < 8; ch++) begin
      b = pixb(mode, cv, r, c, ch);
      v[ch*8 +: 8] = b[7:0];
    end
    return v;
  endfunction

  function automatic logic [63:0] golden(input int mode, input int cv, input int r, input int c);
    logic [63:0] v;
    int s;
    int o;
    v = '0;
    for (int ch = 0; ch < 8; ch++) begin
      s = 0;
      for (int dy = 0; dy < 3; dy++)
        for (int dx = 0; dx < 3; dx++)
          s += pixb(mode, cv, r - 2 + dy, c - 2 + dx, ch);
      if (s < 0) o = 0;
      else if (s >= 256) o = 127;
      else o = s / 2;
      v[ch*8 +: 8] = o[7:0];
    end
    return v;
  endfunction

  // Expected valid/eof pipeline: a pixel driven before edge N shows at N+2.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv1 <= 1'b0; pv2 <= 1'b0; pe1 <= 1'b0; pe2 <= 1'b0;
    end else begin
      pv1 <= fire_now; pv2 <= pv1;
      pe1 <= eof_now;  pe2 <= pe1;
    end
  end

  always @(negedge clk) begin
    if (!rstn) last_act = '0;
    tests++;
    assert (out_valid === pv2) else begin
      failed++;
      $error("FAIL valid_timing: observed %b expected %b at %0t", out_valid, pv2, $time);
    end
    if (out_valid === 1'b1) begin
      n_out++;
      if (out_eof === 1'b1) n_eof++;
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      tests++;
      assert (out_act === exp_v) else begin
        failed++;
        $error("FAIL out_act: observed %h expected %h at %0t", out_act, exp_v, $time);
      end
      tests++;
      assert (out_eof === pe2) else begin
        failed++;
        $error("FAIL out_eof: observed %b expected %b at %0t", out_eof, pe2, $time);
      end
      last_act = out_act;
    end else begin
      tests++;
      assert (out_eof === 1'b0 && out_act === last_act) else begin
        failed++;
        $error("FAIL hold: observed act=%h eof=%b expected act=%h eof=0 at %0t",
               out_act, out_eof, last_act, $time);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_sof = 1'b0; fire_now = 1'b0; eof_now = 1'b0;
    end
  endtask

  task automatic drive(input logic [63:0] d, input logic sof, input logic fire,
                       input logic eof, input logic [63:0] expv);
    @(posedge clk); #1;
    in_valid = 1'b1; in_sof = sof; in_act = d;
    fire_now = fire; eof_now = eof;
    if (fire) exp_q.push_back(expv);
  endtask

  task automatic send_frame(input int mode, input int cv, input bit gaps, input int npix);
    int r, c;
    logic f;
    for (int i = 0; i < npix; i++) begin
      r = i / 16; c = i % 16;
      if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      f = (r >= 2 && c >= 2);
      drive(pixvec(mode, cv, r, c), i == 0, f, i == 255,
            f ? golden(mode, cv, r, c) : 64'h0);
    end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_act = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    assert (out_valid === 1'b0) else begin failed++; $error("FAIL rst_valid: observed %b expected 0", out_valid); end
    tests++;
    assert (out_eof === 1'b0) else begin failed++; $error("FAIL rst_eof: observed %b expected 0", out_eof); end
    tests++;
    assert (out_act === 64'h0) else begin failed++; $error("FAIL rst_act: observed %h expected 0", out_act); end
    @(posedge clk); #1; rstn = 1'b1;

    // Pixels without sof after reset are dropped.
    for (int i = 0; i < 20; i++) drive(64'h5555_5555_5555_5555, 1'b0, 1'b0, 1'b0, 64'h0);
    idle(3);

    // Constant 2, continuous: 196 outputs of 9, one eof.
    n_out = 0; n_eof = 0;
    send_frame(0, 2, 0, 256);
    idle(4);
    tests++;
    assert (n_out == 196) else begin failed++; $error("FAIL count_const2: observed %0d expected 196", n_out); end
    tests++;
    assert (n_eof == 1) else begin failed++; $error("FAIL eof_count: observed %0d expected 1", n_eof); end

    // -1 gives zero, 127 saturates, back to back.
    send_frame(0, -1, 0, 256);
    send_frame(0, 127, 0, 256);
    idle(4);

    // Ramp data with random gaps.
    n_out = 0;
    send_frame(1, 0, 1, 256);
    idle(4);
    tests++;
    assert (n_out == 196) else begin failed++; $error("FAIL count_gaps: observed %0d expected 196", n_out); end

    // Garbage, then a partial frame resynchronised by sof at pixel 40.
    for (int i = 0; i < 7; i++) drive(64'h1234_5678_9abc_def0, 1'b0, 1'b0, 1'b0, 64'h0);
    n_eof = 0;
    send_frame(1, 0, 0, 40);
    send_frame(1, 0, 0, 256);
    idle(4);
    tests++;
    assert (n_eof == 1) else begin failed++; $error("FAIL resync_eof: observed %0d expected 1", n_eof); end

    // Reset during row 5; in-flight outputs dropped.
    send_frame(0, 2, 0, 88);
    @(posedge clk); #1;
    rstn = 1'b0; in_valid = 1'b0; in_sof = 1'b0; fire_now = 1'b0; eof_now = 1'b0;
    exp_q.delete();
    idle(2);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) drive(64'h0202_0202_0202_0202, 1'b0, 1'b0, 1'b0, 64'h0);
    n_out = 0;
    send_frame(1, 0, 0, 256);
    idle(5);
    tests++;
    assert (n_out == 196) else begin failed++; $error("FAIL count_after_reset: observed %0d expected 196", n_out); end
    tests++;
    assert (exp_q.size() == 0) else begin failed++; $error("FAIL leftover: observed %0d expected 0", exp_q.size()); end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/conv2_dw.md
CONV2_DW -- requirements
Module: conv2_dw

Interface
REQ-001 Parameter IMG_W, default 16: pixels per row, range 3..64.
REQ-002 Parameter IMG_H, default 16: rows per frame, range 3..64.
REQ-003 Parameter DW_WEIGHTS, default all 16'sd16384: 72 x 16-bit signed packed; W[c][k] at bits [(c*9+k)*16 +: 16]; c = channel 0..7; k = ky*3+kx, kx/ky 0..2; oldest row/column at index 0.
REQ-004 Parameter DW_BIAS, default all 16'd0: 8 x 16-bit unsigned packed; B[c] at bits [c*16 +: 16].
REQ-005 clk  in  1  clock; all logic rising-edge.
REQ-006 rstn  in  1  reset, asynchronous, active-low.
REQ-007 in_valid  in  1  in_act/in_sof carry one pixel this cycle; no backpressure.
REQ-008 in_sof  in  1  qualified by in_valid; pixel is row 0, column 0 of a frame.
REQ-009 in_act  in  64  8 channels x 8-bit signed; channel c at bits [8c+7:8c].
REQ-010 out_act  out  64  8 channels x 8-bit result; channel c at bits [8c+7:8c]; feeds the pointwise stage input.
REQ-011 out_valid  out  1  out_act holds a valid output pixel this cycle; drives the pointwise stage valid.
REQ-012 out_eof  out  1  high with out_valid on the last output pixel of a frame.

Function
REQ-013 The block SHALL compute a 3x3 depthwise convolution, stride 1, no padding: (IMG_H-2)x(IMG_W-2) outputs per frame, raster order.
REQ-014 FSM SHALL have two states: WAIT_SOF (after reset) and ACTIVE.
REQ-015 In WAIT_SOF, pixels with in_valid=1 and in_sof=0 SHALL be dropped, with no state change.
REQ-016 A pixel with in_valid=1 and in_sof=1 SHALL be stored as (row 0, col 0) and move the FSM to ACTIVE; this applies in either state and also resynchronises mid-frame.
REQ-017 In ACTIVE, col SHALL increment on each accepted pixel, wrap IMG_W-1 -> 0, and increment row on wrap.
REQ-018 Acceptance of pixel (IMG_H-1, IMG_W-1) SHALL return the FSM to WAIT_SOF and clear row and col to 0.
REQ-019 Cycles with in_valid=0 SHALL leave counters, line buffers and window unchanged; gaps of any length are legal.
REQ-020 Two line buffers, each IMG_W x 64 bits, SHALL hold rows r-1 and r-2; writes SHALL occur only on accepted pixels.
REQ-021 A 3x3 window register of 64-bit pixels SHALL shift one column per accepted pixel.
REQ-022 Accepting pixel (r,c) with r>=2 and c>=2 SHALL produce an output for the window covering rows r-2..r and cols c-2..c; no output otherwise.
REQ-023 Latency: out_valid SHALL assert exactly 2 cycles after the in_valid cycle of the triggering pixel, for one cycle.
REQ-024 Arithmetic per channel: acc = sum over k of W[c][k] * signed pixel byte, 32-bit signed, plus zero-extended B[c], with no intermediate truncation.
REQ-025 Requantisation per channel:
  - acc < 0 -> 8'd0
  - acc[31:22] != 0 -> 8'd127
  - otherwise {1'b0, acc[21:15]}
REQ-026 out_act SHALL hold its last value when out_valid=0.
REQ-027 out_eof SHALL assert only for the output triggered by pixel (IMG_H-1, IMG_W-1).
REQ-028 A resync in_sof mid-frame SHALL discard partial-frame state; that frame produces no out_eof; outputs resume at (2,2) of the new frame.

Reset
REQ-029 While rstn=0:
  - out_act = 0, out_valid = 0, out_eof = 0
  - FSM = WAIT_SOF, row = col = 0
  - pipeline valid bits cleared
REQ-030 Line buffer and window contents need not be reset; stale data SHALL never reach out_act with out_valid=1.
REQ-031 Reset asserted mid-frame SHALL drop all in-flight outputs; out_valid SHALL be 0 from the reset edge until 2 cycles after pixel (2,2) of a new sof-started frame.

Verification
REQ-032 Default parameters, 16x16 frame, every byte = 2, in_valid continuous -> 196 out_valid pulses, every byte 8'd9, out_eof on the 196th only, first out_valid 2 cycles after pixel (2,2).
REQ-033 Every byte = 8'hFF (-1) -> all outputs 8'd0; every byte = 127 -> all outputs 8'd127 (acc = 18726912, saturated).
REQ-034 Random in_valid gaps (50% duty), ramp data per channel -> outputs match golden model bit-exactly and in order; no output during gaps except the 2-cycle pipeline tail.
REQ-035 Pixels without sof after reset -> no output; then sof at pixel 40 of a frame mid-stream -> counters resync, outputs start at (2,2) of the new frame.
REQ-036 rstn pulsed low at row 5 -> out_valid drops immediately, stays 0 until a new frame's pixel (2,2) + 2 cycles; outputs of the next full frame are correct.
